// File: rtl/spi_adc_scanner.sv
// Round-robin SPI master for a multi-channel serial ADC: each frame sends a
// start/single-ended/channel command and returns one channel-tagged sample.
module spi_adc_scanner #(
  parameter int DATA_W  = 12,
  parameter int CH_N    = 4,
  parameter int CH_W    = 2,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              single,
  input  logic [CH_N-1:0]   ch_mask,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic              CS,
  output logic [DATA_W-1:0] o_DATA,
  output logic [CH_W-1:0]   o_CH,
  output logic              DATA_VALID,
  output logic              busy
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_q;
  logic               sck_hi_q;
  logic [CH_W-1:0]    ch_q;
  logic [CH_W-1:0]    ptr_q;
  logic               pend_q;
  logic [DATA_W-1:0]  shreg_q;
  logic               cs_q;
  logic               sck_q;
  logic               mosi_q;
  logic [DATA_W-1:0]  data_q;
  logic [CH_W-1:0]    och_q;
  logic               dv_q;
  logic               busy_q;

  logic               start_d;
  logic [CH_W-1:0]    sel_ch_d;
  logic [FRAME_W-1:0] cmd_d;
  logic [BIT_W-1:0]   nxt_bit_d;
  logic [CH_W-1:0]    nxt_ptr_d;
  logic               div_end_d;
  logic               gap_end_d;

  // Lowest enabled channel at or above ptr, otherwise wrap to the lowest enabled one.
  function automatic logic [CH_W-1:0] pick_ch(input logic [CH_N-1:0] mask,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] sel;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < CH_N; i++) begin
      if (!found && mask[i] && (i >= int'(ptr))) begin
        sel   = CH_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < CH_N; i++) begin
      if (!found && mask[i]) begin
        sel   = CH_W'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [FRAME_W-1:0] cmd_word(input logic [CH_W-1:0] ch);
    logic [FRAME_W-1:0] w;
    w    = '0;
    w[0] = 1'b1;
    w[1] = 1'b1;
    for (int j = 0; j < CH_W; j++) begin
      w[2+j] = ch[CH_W-1-j];
    end
    return w;
  endfunction

  // Frame-start decision, channel selection and command lookup.
  always_comb begin
    start_d   = (ch_mask != '0) && (enable || single || pend_q);
    sel_ch_d  = pick_ch(ch_mask, ptr_q);
    cmd_d     = cmd_word(ch_q);
    nxt_bit_d = bit_q + 1'b1;
    div_end_d = (cnt_q == CNT_W'(CLK_DIV - 1));
    gap_end_d = (cnt_q == CNT_W'(GAP_CYC - 1));
    if (ch_q == CH_W'(CH_N - 1)) begin
      nxt_ptr_d = '0;
    end else begin
      nxt_ptr_d = ch_q + 1'b1;
    end
  end

  // Scanner FSM with all pin and result outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_hi_q <= 1'b0;
      ch_q     <= '0;
      ptr_q    <= '0;
      pend_q   <= 1'b0;
      shreg_q  <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      data_q   <= '0;
      och_q    <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (start_d) begin
            state_q <= SETUP;
            cnt_q   <= '0;
            ch_q    <= sel_ch_d;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          pend_q <= pend_q | single;
          if (div_end_d) begin
            state_q  <= SHIFT;
            cnt_q    <= '0;
            bit_q    <= '0;
            sck_hi_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          pend_q <= pend_q | single;
          if (!div_end_d) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (!sck_hi_q) begin
              // MISO is captured on the same edge that raises SCK.
              sck_q    <= 1'b1;
              sck_hi_q <= 1'b1;
              shreg_q  <= {shreg_q[DATA_W-2:0], MISO};
            end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_q  <= HOLD;
              sck_q    <= 1'b0;
              sck_hi_q <= 1'b0;
              mosi_q   <= 1'b0;
            end else begin
              bit_q    <= nxt_bit_d;
              sck_q    <= 1'b0;
              sck_hi_q <= 1'b0;
              mosi_q   <= cmd_d[nxt_bit_d];
            end
          end
        end
        HOLD: begin
          pend_q <= pend_q | single;
          if (div_end_d) begin
            state_q <= GAP;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            data_q  <= shreg_q;
            och_q   <= ch_q;
            dv_q    <= 1'b1;
            ptr_q   <= nxt_ptr_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (!gap_end_d) begin
            cnt_q  <= cnt_q + 1'b1;
            pend_q <= pend_q | single;
          end else if (start_d) begin
            // A single arriving here is absorbed by the start it coincides with.
            state_q <= SETUP;
            cnt_q   <= '0;
            ch_q    <= sel_ch_d;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            pend_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CS         = cs_q;
  assign SCK        = sck_q;
  assign MOSI       = mosi_q;
  assign o_DATA     = data_q;
  assign o_CH       = och_q;
  assign DATA_VALID = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Scoreboard bench for spi_adc_scanner: an ADC model decodes the command and
// returns per-channel samples; a monitor checks every DATA_VALID against a queue.
`timescale 1ns/1ps
module tb_spi_adc_scanner;

  localparam int DATA_W    = 12;
  localparam int CH_N      = 4;
  localparam int CH_W      = 2;
  localparam int FRAME_W   = 16;
  localparam int CLK_DIV   = 2;
  localparam int GAP_CYC   = 2;
  localparam int CS_LOW    = 68;
  localparam int FRAME_CYC = 70;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              single;
  logic [CH_N-1:0]   ch_mask;
  logic              MISO;
  logic              MOSI;
  logic              SCK;
  logic              CS;
  logic [DATA_W-1:0] o_DATA;
  logic [CH_W-1:0]   o_CH;
  logic              DATA_VALID;
  logic              busy;

  spi_adc_scanner #(
    .DATA_W(DATA_W), .CH_N(CH_N), .CH_W(CH_W),
    .FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .single(single),
    .ch_mask(ch_mask), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .CS(CS),
    .o_DATA(o_DATA), .o_CH(o_CH), .DATA_VALID(DATA_VALID), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  int                tests = 0;
  int                fails = 0;
  int                dv_count = 0;
  int                cyc = 0;
  int                last_dv = -1;
  bit                spacing_en = 1'b0;
  logic [DATA_W-1:0] adc_val [CH_N];
  exp_t              exp_q[$];
  logic [CH_W-1:0]   mosi_chq[$];
  exp_t              mon_e;

  bit                 m_active;
  int                 m_per, m_rises, m_low;
  logic [FRAME_W-1:0] m_cmd;
  logic [CH_W-1:0]    m_ch;
  logic               prev_cs, prev_sck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic miso_bit(input int p, input logic [CH_W-1:0] c);
    logic [DATA_W-1:0] v;
    v = adc_val[c];
    if (p < FRAME_W - DATA_W) return 1'b1;
    else if (p < FRAME_W) return v[FRAME_W-1-p];
    else return 1'b0;
  endfunction

  task automatic push_exp(input logic [CH_W-1:0] c);
    exp_q.push_back(exp_t'({c, adc_val[c]}));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_single();
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
  endtask

  task automatic wait_dv(input int target, input int budget);
    int n;
    n = 0;
    while (dv_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dv_wait", dv_count, target);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: decodes the command from MOSI and drives MISO after each SCK fall.
  always @(negedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      mosi_chq.delete();
      MISO     = 1'b0;
      prev_cs  = 1'b1;
      prev_sck = 1'b0;
    end else begin
      if (!CS && prev_cs) begin
        m_active = 1'b1;
        m_per    = 0;
        m_rises  = 0;
        m_low    = 0;
        m_cmd    = '0;
        m_ch     = '0;
        MISO     = miso_bit(0, m_ch);
      end
      if (m_active) begin
        if (!CS) m_low++;
        if (SCK && !prev_sck) begin
          m_rises++;
          if (m_per < FRAME_W) m_cmd[m_per] = MOSI;
          if (m_per == 1 + CH_W) begin
            for (int j = 0; j < CH_W; j++) m_ch[CH_W-1-j] = m_cmd[2+j];
            mosi_chq.push_back(m_ch);
          end
        end
        if (!SCK && prev_sck) begin
          m_per++;
          MISO = miso_bit(m_per, m_ch);
        end
        if (CS && !prev_cs) begin
          chk("cs_low_cycles", m_low, CS_LOW);
          chk("sck_rises", m_rises, FRAME_W);
          chk("mosi_start_se", m_cmd[1:0], 2'b11);
          chk("mosi_tail_zero", m_cmd[FRAME_W-1:2+CH_W], 0);
          m_active = 1'b0;
        end
      end
      prev_cs  = CS;
      prev_sck = SCK;
    end
  end

  // Monitor: every DATA_VALID pops the scoreboard and the decoded MOSI channel.
  always @(negedge clk) begin
    if (!reset && DATA_VALID === 1'b1) begin
      dv_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_dv", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("o_CH", o_CH, mon_e.ch);
        chk("o_DATA", o_DATA, mon_e.data);
      end
      if (mosi_chq.size() == 0) begin
        chk("mosi_ch_avail", mosi_chq.size(), 1);
      end else begin
        chk("mosi_ch_vs_o_CH", o_CH, mosi_chq.pop_front());
      end
      if (spacing_en && last_dv >= 0) chk("dv_spacing", cyc - last_dv, FRAME_CYC);
      last_dv = cyc;
    end
  end

  initial begin
    int   n, base;
    logic ok_cs, ok_busy;
    adc_val[0] = 12'hA5C;
    adc_val[1] = 12'h3C1;
    adc_val[2] = 12'h5F0;
    adc_val[3] = 12'h9E7;
    reset   = 1'b1;
    enable  = 1'b0;
    single  = 1'b0;
    ch_mask = 4'b0000;
    step(3);
    chk("rst_cs", CS, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_data", o_DATA, 0);
    chk("rst_ch", o_CH, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(3);

    // Single frame on channel 0.
    ch_mask = 4'b0001;
    exp_q.push_back(exp_t'({2'd0, 12'hA5C}));
    pulse_single();
    n = 0;
    while (DATA_VALID !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("single_dv_seen", DATA_VALID, 1);
    chk("single_cs_at_dv", CS, 1);
    chk("single_busy_at_dv", busy, 1);
    @(negedge clk);
    chk("single_dv_one_cycle", DATA_VALID, 0);
    chk("single_busy_gap", busy, 1);
    @(negedge clk);
    chk("single_busy_fall", busy, 0);
    step(20);
    chk("hold_data", o_DATA, 12'hA5C);
    chk("hold_ch", o_CH, 0);

    // Abort a channel-1 frame with reset while SCK is high.
    ch_mask = 4'b0010;
    pulse_single();
    step(28);
    chk("pre_rst_cs", CS, 0);
    chk("pre_rst_sck", SCK, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_cs", CS, 1);
    chk("async_rst_sck", SCK, 0);
    chk("async_rst_busy", busy, 0);
    step(2);
    reset = 1'b0;
    base = dv_count;
    step(150);
    chk("abort_no_dv", dv_count, base);

    // Continuous scan over mask 1011.
    spacing_en = 1'b1;
    last_dv    = -1;
    base       = dv_count;
    push_exp(2'd0); push_exp(2'd1); push_exp(2'd3);
    push_exp(2'd0); push_exp(2'd1); push_exp(2'd3);
    ch_mask = 4'b1011;
    enable  = 1'b1;
    wait_dv(base + 5, 600);
    step(10);
    enable = 1'b0;
    wait_dv(base + 6, 200);
    wait_idle(20);

    // Mask change during the channel-1 frame.
    last_dv = -1;
    base    = dv_count;
    push_exp(2'd0); push_exp(2'd1); push_exp(2'd2); push_exp(2'd2); push_exp(2'd2);
    ch_mask = 4'b1111;
    enable  = 1'b1;
    wait_dv(base + 1, 200);
    step(20);
    ch_mask = 4'b0100;
    wait_dv(base + 4, 400);
    step(10);
    enable = 1'b0;
    wait_dv(base + 5, 200);
    wait_idle(20);
    spacing_en = 1'b0;

    // Empty mask: nothing starts, single dropped.
    base    = dv_count;
    ch_mask = 4'b0000;
    enable  = 1'b1;
    ok_cs   = 1'b1;
    ok_busy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (CS !== 1'b1) ok_cs = 1'b0;
      if (busy !== 1'b0) ok_busy = 1'b0;
    end
    chk("mask0_cs_high", ok_cs, 1);
    chk("mask0_busy_low", ok_busy, 1);
    pulse_single();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (CS !== 1'b1) ok_cs = 1'b0;
      if (busy !== 1'b0) ok_busy = 1'b0;
    end
    chk("mask0_single_cs", ok_cs, 1);
    chk("mask0_single_busy", ok_busy, 1);
    chk("mask0_no_dv", dv_count, base);
    enable = 1'b0;
    step(2);

    // Enable drops mid-frame with two singles while busy: one extra frame.
    base = dv_count;
    push_exp(2'd1); push_exp(2'd2);
    ch_mask = 4'b0110;
    enable  = 1'b1;
    step(20);
    enable = 1'b0;
    pulse_single();
    step(5);
    pulse_single();
    wait_dv(base + 2, 400);
    step(300);
    chk("pend_one_extra", dv_count, base + 2);
    chk("pend_end_idle", busy, 0);
    chk("pend_end_cs", CS, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
- Parametrised SPI master that scans a multi-channel serial ADC.
- Round-robins the enabled channels in a mask and returns one DATA_W-bit sample per frame, tagged with its channel number.
- Successor to the fixed single-channel 12-bit SPI reader: width, frame length, channel count, SCK rate and inter-frame gap are all configurable, and it adds continuous and single-shot modes.
- Sits between the ADC pins and the display and threshold logic; runs directly on the system clock, no external prescaler.

Parameters:
- DATA_W, 12: sample width, taken from the last DATA_W bits of each frame.
- CH_N, 4: number of ADC channels.
- CH_W, 2: channel index width; CH_N <= 2^CH_W.
- FRAME_W, 16: SCK cycles per frame. Constraint: FRAME_W >= 2 + CH_W + DATA_W.
- CLK_DIV, 4: clk cycles per SCK half-period; >= 1.
- GAP_CYC, 2: clk cycles CS stays high between frames; >= 1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: continuous-scan request (level).
- single, in, 1: one-cycle pulse; requests one frame on the next enabled channel.
- ch_mask, in, CH_N: channel enables; bit i enables channel i.
- MISO, in, 1: ADC serial data out.
- MOSI, out, 1: command bits to the ADC.
- SCK, out, 1: serial clock, mode 0, idles low.
- CS, out, 1: chip select, active low.
- o_DATA, out, DATA_W: last captured sample.
- o_CH, out, CH_W: channel of o_DATA.
- DATA_VALID, out, 1: one-cycle pulse when o_DATA/o_CH update.
- busy, out, 1: high from frame start until the end of GAP.

Behaviour:
- Reset (asynchronous, immediate): CS=1, SCK=0, MOSI=0, o_DATA=0, o_CH=0, DATA_VALID=0, busy=0, state=IDLE, channel pointer=0. Reset mid-frame aborts the frame with no DATA_VALID.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP when (enable or single) and ch_mask != 0.
  - Channel chosen = lowest enabled index >= pointer, wrapping to the lowest enabled index.
  - ch_mask is sampled only at this point; later changes affect the next selection only.
  - ch_mask == 0: stay in IDLE; single is dropped.
- SETUP (CLK_DIV cycles): CS=0, SCK=0, MOSI = command bit 0.
- SHIFT: FRAME_W SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - MOSI changes only on entry to a low phase.
  - MISO is sampled on the clk cycle SCK rises, shifted in MSB first.
- Command word, bit k sent in period k:
  - k=0: 1 (start bit).
  - k=1: 1 (single-ended).
  - k=2 .. 1+CH_W: channel index, MSB first.
  - remaining bits: 0.
- Sample = MISO bits from periods FRAME_W-DATA_W .. FRAME_W-1; earlier bits are discarded.
- HOLD (CLK_DIV cycles, SCK=0): on the final cycle CS rises. In the same cycle o_DATA and o_CH load and DATA_VALID=1 for exactly one cycle. The pointer is then set to channel+1 mod CH_N.
- GAP (GAP_CYC cycles, CS=1):
  - enable high -> SETUP, with the next channel selected as above.
  - enable low -> IDLE, busy=0.
- Frame period = 2*CLK_DIV + 2*CLK_DIV*FRAME_W + GAP_CYC cycles.
- enable dropped mid-frame: the current frame completes and DATA_VALID is produced; then IDLE.
- single while busy: latched as a pending request, and only one is held. After GAP it starts one frame even if enable=0. A single coinciding with an enable-driven start is absorbed by that start.
- o_DATA/o_CH hold their values between DATA_VALID pulses.

Test Plan:
- Reset mid-SHIFT (defaults): CS=1, SCK=0 immediately; no DATA_VALID; the next frame starts at channel 0.
- Defaults, CLK_DIV=2, GAP_CYC=2, ch_mask=4'b0001, single pulse:
  - CS low for 68 cycles.
  - 16 SCK rising edges.
  - MOSI sequence 1,1,0,0 then 0s.
  - ADC model drives 0xA5C in the last 12 bits -> DATA_VALID once, o_DATA=0xA5C, o_CH=0, busy falls 2 cycles after CS rises.
- enable=1, ch_mask=4'b1011 -> o_CH sequence 0,1,3,0,1,3; DATA_VALID spaced 70 cycles apart; MOSI channel bits match o_CH.
- enable=1, ch_mask changed 4'b1111->4'b0100 during a channel-1 frame -> that frame completes with o_CH=1; the following frames are all channel 2.
- ch_mask=0 with enable=1 -> CS stays 1, busy=0, no DATA_VALID for 500 cycles. A single pulse with mask 0 is also dropped.
- enable falls mid-frame, plus two single pulses while busy -> the current frame completes, exactly one extra frame follows, then IDLE.
